interval_query_initiator: RTL and testbench
===========================================

INTERVAL_QUERY_INITIATOR -- requirements
Module: interval_query_initiator

Interface
REQ-001 Parameter LOOKBACK_MAX, default 8: largest legal lookback; equals the tracker BUFFER_WIDTH.
REQ-002 Parameter RESP_WAIT, default 2: cycles between the recalculate_time pulse and sampling time_in; must be at least 1.
REQ-003 Parameter FIFO_DEPTH, default 4: result FIFO entries; must be a power of 2 and at least 2.
REQ-004 Port clk, input, 1: single clock; all logic on posedge.
REQ-005 Port rst, input, 1: reset, synchronous, active-low.
REQ-006 Port counter, input, 32: free-running cycle count shared with the tracker.
REQ-007 Ports req_valid (input, 1), req_ready (output, 1), req_lookback (input, 32): query request handshake.
REQ-008 Ports recalculate_time (output, 1) and value_in (output, 32): query to the tracker.
REQ-009 Port time_in, input, 2x32 signed: tracker response; [0] is start, [1] is end, and -1 means none.
REQ-010 Ports update_end (output, 1) and previous_end_o (output, 32): previous-end override to the tracker.
REQ-011 Ports res_valid (output, 1), res_ready (input, 1), res_start (output, 32 signed), res_end (output, 32 signed), res_status (output, 3), res_stamp (output, 32): result stream.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT and CAPTURE.
REQ-013 req_ready SHALL be 1 only in IDLE with FIFO count < FIFO_DEPTH; a request is accepted when req_valid and req_ready are both 1.
REQ-014 On accept with req_lookback == 0 or > LOOKBACK_MAX, the block SHALL push {-1, -1, REJECTED, counter} in the same cycle and stay in IDLE.
REQ-015 On a legal accept, the block SHALL latch value_in = req_lookback and stamp = counter, then go to ISSUE.
REQ-016 In ISSUE, recalculate_time SHALL be 1 for exactly one cycle; then go to WAIT.
REQ-017 recalculate_time SHALL be 0 in every other state, so the tracker sees one rising edge per query.
REQ-018 WAIT SHALL last exactly RESP_WAIT cycles, counted by a down-counter, then go to CAPTURE.
REQ-019 Sampling latency: time_in is sampled RESP_WAIT+1 cycles after the recalculate_time rising edge.
REQ-020 In CAPTURE, the block SHALL sample time_in and classify it:
- start = -1: NO_START.
- start != -1 and end = -1: NO_END.
- otherwise: OK.
REQ-021 CAPTURE SHALL push one FIFO entry and return to IDLE in one cycle; space is guaranteed because at most one query is outstanding.
REQ-022 value_in SHALL hold its latched value from ISSUE through CAPTURE.
REQ-023 Result FIFO rules:
- res_valid = !empty; head data is stable while res_valid && !res_ready.
- Pop on res_valid && res_ready.
- Simultaneous push and pop is legal at any count and leaves the count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
REQ-024 update_end SHALL be 0 except as stated in REQ-029.
REQ-025 previous_end_o SHALL hold its last driven value.

Reset
REQ-026 While rst == 0 at a posedge, the block SHALL reset, including mid-query:
- state to IDLE and the FIFO to empty;
- recalculate_time, update_end, res_valid and req_ready to 0;
- value_in, previous_end_o and the wait counter to 0.
REQ-027 An in-flight query SHALL be discarded with no FIFO entry; req_ready becomes 1 in the first cycle after rst returns to 1.

Configuration
REQ-028 Macro FORCE_CLOSE_EN controls forced closing of open intervals.
REQ-029 With FORCE_CLOSE_EN defined, a NO_END response SHALL instead:
- push {start, stamp-1, FORCED, stamp};
- drive update_end = 1 for one cycle, concurrent with the push, with previous_end_o = stamp-1.
REQ-030 Without FORCE_CLOSE_EN, NO_END SHALL be reported as-is, update_end SHALL be tied 0 and the FORCED encoding SHALL never appear.

Structure
REQ-031 Package interval_query_pkg SHALL hold:
- the state enum;
- the status enum: OK=0, NO_START=1, NO_END=2, REJECTED=3, FORCED=4;
- the result struct {start, end, status, stamp};
- the constant TIME_NONE = -1.
REQ-032 FIFO storage SHALL be a sub-module, interval_result_fifo, parameterised by depth and using the package struct.

Verification
REQ-033 Bench SHALL cover these directed scenarios (RESP_WAIT=2):
- Lookback 3 with time_in = {12, 14} at CAPTURE: recalculate_time is high for 1 cycle; entry is {12, 14, OK}; update_end stays 0.
- Lookback 0, then lookback 9: two REJECTED entries {-1, -1}; recalculate_time never rises.
- time_in = {20, -1} with stamp = 25: with the macro, entry {20, 24, FORCED}, update_end pulses once and previous_end_o = 24; without it, entry {20, -1, NO_END}.
- FIFO_DEPTH=4, res_ready held 0, 5 requests: 4 entries accepted, req_ready = 0 after the 4th; one pop re-enables it and FIFO order is preserved.
- rst driven low during WAIT: next cycle is IDLE, the FIFO is empty and no entry appears for that query.

Source files
------------

// File: rtl/interval_query_pkg.sv
// rtl/interval_query_pkg.sv - shared states, status codes and result record for the interval query initiator
package interval_query_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } state_e;

    typedef enum logic [2:0] {
        OK       = 3'd0,
        NO_START = 3'd1,
        NO_END   = 3'd2,
        REJECTED = 3'd3,
        FORCED   = 3'd4
    } status_e;

    typedef struct packed {
        logic signed [31:0] start_time;
        logic signed [31:0] end_time;
        status_e            status;
        logic [31:0]        stamp;
    } result_t;

    localparam logic signed [31:0] TIME_NONE = -32'sd1;

endpackage

// File: rtl/interval_result_fifo.sv
// rtl/interval_result_fifo.sv - power-of-two result FIFO holding interval query records
module interval_result_fifo
    import interval_query_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output result_t head,
    output logic    empty,
    output logic    full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    result_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/interval_query_initiator.sv
// rtl/interval_query_initiator.sv - issues one lookback query at a time to the tracker and queues classified results
// Define FORCE_CLOSE_EN to close open intervals at stamp-1 and push the override back to the tracker.
module interval_query_initiator
    import interval_query_pkg::*;
#(
    parameter int LOOKBACK_MAX = 8,
    parameter int RESP_WAIT    = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        counter,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_lookback,
    output logic               recalculate_time,
    output logic [31:0]        value_in,
    input  logic [1:0][31:0]   time_in,
    output logic               update_end,
    output logic [31:0]        previous_end_o,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [31:0] res_start,
    output logic signed [31:0] res_end,
    output logic [2:0]         res_status,
    output logic [31:0]        res_stamp
);
    state_e             state;
    state_e             state_nx;
    logic [31:0]        wait_cnt;
    logic [31:0]        stamp_q;
    logic [31:0]        prev_end_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               force_close;
    logic               accept;
    logic               bad_lookback;
    logic signed [31:0] t_start;
    logic signed [31:0] t_end;
    result_t            push_data;
    result_t            head;

    assign t_start      = time_in[0];
    assign t_end        = time_in[1];
    assign req_ready    = rst && (state == IDLE) && !fifo_full;
    assign accept       = req_valid && req_ready;
    assign bad_lookback = (req_lookback == 32'd0) || (req_lookback > 32'(LOOKBACK_MAX));

    always_comb begin
        state_nx         = state;
        push             = 1'b0;
        push_data        = '0;
        recalculate_time = 1'b0;
        force_close      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad_lookback) begin
                        push                 = 1'b1;
                        push_data.start_time = TIME_NONE;
                        push_data.end_time   = TIME_NONE;
                        push_data.status     = REJECTED;
                        push_data.stamp      = counter;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                recalculate_time = 1'b1;
                state_nx         = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 32'd0) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                push                 = 1'b1;
                state_nx             = IDLE;
                push_data.start_time = t_start;
                push_data.end_time   = t_end;
                push_data.stamp      = stamp_q;
                if (t_start == TIME_NONE) begin
                    push_data.status = NO_START;
                end else if (t_end == TIME_NONE) begin
`ifdef FORCE_CLOSE_EN
                    force_close        = 1'b1;
                    push_data.end_time = stamp_q - 32'd1;
                    push_data.status   = FORCED;
`else
                    push_data.status = NO_END;
`endif
                end else begin
                    push_data.status = OK;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            value_in   <= '0;
            stamp_q    <= '0;
            prev_end_q <= '0;
        end else begin
            state <= state_nx;
            if (accept && !bad_lookback) begin
                value_in <= req_lookback;
                stamp_q  <= counter;
            end
            // Loaded one short so WAIT spans exactly RESP_WAIT cycles including the zero cycle.
            if (state == ISSUE) begin
                wait_cnt <= 32'(RESP_WAIT - 1);
            end else if (state == WAIT && wait_cnt != 32'd0) begin
                wait_cnt <= wait_cnt - 32'd1;
            end
            if (force_close) begin
                prev_end_q <= stamp_q - 32'd1;
            end
        end
    end

    assign update_end     = force_close;
    assign previous_end_o = force_close ? (stamp_q - 32'd1) : prev_end_q;

    interval_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (res_ready),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign res_valid  = !fifo_empty;
    assign res_start  = head.start_time;
    assign res_end    = head.end_time;
    assign res_status = head.status;
    assign res_stamp  = head.stamp;

endmodule

// File: tb/tb_interval_query_initiator.sv
// tb/tb_interval_query_initiator.sv - scoreboard bench with a tracker stand-in and a reference result model
module tb_interval_query_initiator;
    localparam int LB_MAX = 8;
    localparam int RW     = 2;
    localparam int DEPTH  = 4;

    localparam logic [2:0] S_OK       = 3'd0;
    localparam logic [2:0] S_NO_START = 3'd1;
    localparam logic [2:0] S_NO_END   = 3'd2;
    localparam logic [2:0] S_REJ      = 3'd3;
    localparam logic [2:0] S_FORCED   = 3'd4;
    localparam logic [31:0] NONE      = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        logic [2:0]  st;
        logic [31:0] stamp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      counter = 32'd0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_lookback = 32'd0;
    logic             recalculate_time;
    logic [31:0]      value_in;
    logic [1:0][31:0] time_in;
    logic             update_end;
    logic [31:0]      previous_end_o;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_start;
    logic [31:0]      res_end;
    logic [2:0]       res_status;
    logic [31:0]      res_stamp;

    exp_t        exp_q[$];
    logic [31:0] ue_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          rises      = 0;
    int          exp_rises  = 0;
    int          ready_mode = 0;
    logic [31:0] cur_s = 32'd0;
    logic [31:0] cur_e = 32'd0;

    interval_query_initiator #(
        .LOOKBACK_MAX(LB_MAX),
        .RESP_WAIT   (RW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .counter         (counter),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_lookback    (req_lookback),
        .recalculate_time(recalculate_time),
        .value_in        (value_in),
        .time_in         (time_in),
        .update_end      (update_end),
        .previous_end_o  (previous_end_o),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_start       (res_start),
        .res_end         (res_end),
        .res_status      (res_status),
        .res_stamp       (res_stamp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_event(input string name, input int act, input int req);
        compared++;
        mismatched++;
        $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    function automatic exp_t model(input int lb, input logic [31:0] s, input logic [31:0] e,
                                   input logic [31:0] stamp);
        exp_t r;
        r.stamp = stamp;
        r.s     = s;
        r.e     = e;
        if (lb < 1 || lb > LB_MAX) begin
            r.s  = NONE;
            r.e  = NONE;
            r.st = S_REJ;
        end else if (s == NONE) begin
            r.st = S_NO_START;
        end else if (e == NONE) begin
`ifdef FORCE_CLOSE_EN
            r.e  = stamp - 32'd1;
            r.st = S_FORCED;
`else
            r.st = S_NO_END;
`endif
        end else begin
            r.st = S_OK;
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1 counter = counter + 32'd1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ready_mode == 1) res_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) res_ready = 1'b1;
        end
    end

    // Tracker stand-in: the intended answer is present only in the cycle RW+1 after the pulse.
    initial begin
        int cd;
        cd = 0;
        time_in = {$urandom, $urandom};
        forever begin
            @(negedge clk);
            if (recalculate_time) begin
                cd = RW + 1;
                time_in = {$urandom, $urandom};
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) time_in = {cur_e, cur_s};
                else time_in = {$urandom, $urandom};
            end else begin
                time_in = {$urandom, $urandom};
            end
        end
    end

    initial begin
        logic prev_rc;
        exp_t x;
        prev_rc = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                prev_rc = 1'b0;
            end else begin
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_event("unexpected_entry", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        check("res_start", res_start, x.s);
                        check("res_end", res_end, x.e);
                        check("res_status", {29'd0, res_status}, {29'd0, x.st});
                        check("res_stamp", res_stamp, x.stamp);
                    end
                end
                if (recalculate_time) begin
                    check("recalc_single_cycle", {31'd0, prev_rc}, 32'd0);
                    if (!prev_rc) rises++;
                end
                prev_rc = recalculate_time;
                if (update_end) begin
                    if (ue_q.size() == 0) fail_event("unexpected_update_end", 1, 0);
                    else check("previous_end_o", previous_end_o, ue_q.pop_front());
                end
            end
        end
    end

    task automatic do_req(input int lb, input logic [31:0] s, input logic [31:0] e,
                          input int force_stamp, input bit abort);
        int   n;
        exp_t x;
        n = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_lookback = lb;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_event("req_ready_timeout", n, 200);
            req_valid = 1'b0;
            return;
        end
        cur_s = s;
        cur_e = e;
        if (force_stamp >= 0) counter = force_stamp;
        x = model(lb, s, e, counter);
        if (lb >= 1 && lb <= LB_MAX) exp_rises++;
        if (!abort) begin
            exp_q.push_back(x);
            if (x.st == S_FORCED) ue_q.push_back(x.e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (abort) begin
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            #2;
            check("abort_req_ready", {31'd0, req_ready}, 32'd1);
            check("abort_fifo_empty", {31'd0, res_valid}, 32'd0);
            check("abort_value_in", value_in, 32'd0);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < limit) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0 || res_valid) fail_event("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int          r0;
        int          lb;
        logic [31:0] s;
        logic [31:0] e;

        repeat (3) @(negedge clk);
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_recalc", {31'd0, recalculate_time}, 32'd0);
        check("rst_update_end", {31'd0, update_end}, 32'd0);
        check("rst_value_in", value_in, 32'd0);
        check("rst_previous_end", previous_end_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        ready_mode = 2;
        do_req(3, 32'd12, 32'd14, -1, 1'b0);
        wait_drain(100);

        r0 = rises;
        do_req(0, 32'd1, 32'd2, -1, 1'b0);
        do_req(9, 32'd1, 32'd2, -1, 1'b0);
        wait_drain(100);
        check("reject_no_recalc", rises, r0);

        do_req(5, 32'd20, NONE, 25, 1'b0);
        wait_drain(100);

        ready_mode = 0;
        @(negedge clk);
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            do_req(i + 1, 32'd100 + i, 32'd200 + i, -1, 1'b0);
        end
        repeat (RW + 4) @(negedge clk);
        #2;
        check("full_req_ready", {31'd0, req_ready}, 32'd0);
        check("full_res_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #2;
        check("pop_reenables_ready", {31'd0, req_ready}, 32'd1);
        do_req(4, 32'd300, 32'd301, -1, 1'b0);
        ready_mode = 2;
        wait_drain(200);

        do_req(2, 32'd7, 32'd8, -1, 1'b1);
        repeat (RW + 4) @(negedge clk);
        #2;
        check("abort_no_entry", {31'd0, res_valid}, 32'd0);

        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            lb = int'($urandom_range(0, 10));
            s  = ($urandom_range(0, 3) == 0) ? NONE : $urandom_range(0, 1000);
            e  = ($urandom_range(0, 3) == 0) ? NONE : $urandom_range(0, 1000);
            do_req(lb, s, e, -1, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        ready_mode = 2;
        wait_drain(400);

        repeat (4) @(negedge clk);
        check("recalc_rise_count", rises, exp_rises);
        check("update_end_all_seen", ue_q.size(), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
